fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- Owns the PC and drives a variable-latency instruction memory through a req/ack handshake.
- Presents fetched instructions to decode with a valid/stall handshake.
- Applies branch redirects and exception/flush redirects with a fixed priority.
- Sits between the pipeline control logic and instruction memory, replacing a free-running PC-plus-ROM arrangement.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  decode cannot accept; holds the presented instruction.
- branch_flag_i  in  1  branch redirect request.
- branch_target_i  in  32  branch target address.
- flush_i  in  1  exception/flush redirect; overrides branch.
- new_pc_i  in  32  flush target address.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address.
- imem_ack_i  in  1  memory returns data this cycle.
- imem_rdata_i  in  32  instruction word, valid with ack.
- inst_o  out  32  instruction to decode.
- inst_pc_o  out  32  address of inst_o.
- inst_valid_o  out  1  inst_o is valid.

Behaviour:
- Reset (clk edge with rst=1):
  - pc=RESET_PC; state=IDLE.
  - imem_req_o=0, imem_addr_o=0, inst_o=0, inst_pc_o=0, inst_valid_o=0.
  - drop=0; skid empty.
- States:
  - IDLE: no request. Moves to REQ on the first edge with rst=0.
  - REQ: imem_req_o=1, imem_addr_o=pc.
  - SKID: no new request; data is held in the skid buffer.
- Request contract:
  - Once imem_req_o rises, req and addr stay stable until the cycle of imem_ack_i, whether or not a redirect or stall occurs.
  - At most one request is outstanding.
- Issue rule: a new request starts in REQ only when the output slot is free or being consumed this cycle, i.e. !inst_valid_o || !stall_i.
- Ack handling (edge with req && ack):
  - If drop=1: discard data, clear drop, keep pc as redirected.
  - Otherwise, with slot free or consumed: inst_o=rdata, inst_pc_o=imem_addr_o, inst_valid_o=1, pc+=PC_STEP.
  - Otherwise (slot occupied and stall_i=1): write into a 1-entry skid, pc+=PC_STEP, go to SKID.
- Throughput: with same-cycle ack and no stall, one instruction per cycle. Ack-to-inst_valid_o latency is 1 cycle.
- Consume: edge with inst_valid_o && !stall_i and no new data → inst_valid_o=0.
- SKID: when stall_i=0, skid moves to the output register and the state returns to REQ. The skid never overflows.
- Redirect priority: flush_i > branch_flag_i. On a redirect edge:
  - pc=target.
  - inst_valid_o=0 and skid cleared.
  - State goes to REQ.
  - If a request is outstanding without ack that cycle, set drop=1.
  - A redirect coincident with an ack discards that ack's data.
  - Redirect overrides stall_i.
- Target alignment: target[1:0] is forced to 2'b00 (see optional feature).
- Reset mid-transaction: reset clears drop, the skid and the request. Memory must tolerate an abandoned request.
- pc wraps modulo 2^32.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A redirect with target[1:0]!=0 sets misalign_o sticky, loads pc unmasked, and holds the FSM in IDLE (no requests).
  - misalign_o clears, and fetching resumes, only on a subsequent flush_i with an aligned new_pc_i, or on reset.
- Undefined: no port; low two bits are masked as above.

Test Plan:
- Reset release, ack tied to req, stall=0 → imem_addr_o sequence 0x0,0x4,0x8…; inst_pc_o follows one cycle later; inst_valid_o continuous.
- Ack delayed 3 cycles per request → imem_req_o/addr stable for 4 cycles each; inst_o=rdata, one valid pulse per ack.
- stall_i asserted while valid and an ack arrives → output held unchanged; the data goes to the skid. Dropping stall → skid instruction presented next cycle in order, no loss or duplicate.
- branch_flag_i=1, target 0x100, while a request to 0x8 is pending 2 cycles → 0x8 data discarded, next request addr=0x100, inst_pc_o=0x100.
- flush_i (new_pc 0x380) and branch_flag_i (0x200) in the same cycle → next fetch addr=0x380.
- With FETCH_MISALIGN_CHECK_EN, branch to 0x102 → misalign_o=1, no requests. Flush to 0x380 → misalign_o=0, fetch 0x380. Without the macro, the branch to 0x102 fetches 0x100.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack bus for the fetch sequencer.
// master = fetch side, slave = memory side.
interface fetch_ctrl_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, imem req/ack, decode valid/stall.
// Optional macro FETCH_MISALIGN_CHECK_EN adds misalign_o trapping.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   fetch_ctrl_if.master imem,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalign_o
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SKID = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] ipc_q, ipc_d;
   logic        valid_q, valid_d;
   logic        drop_q, drop_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        mis_q, mis_d;
`endif

   logic        redirect;
   logic [31:0] tgt;
   logic        fire;
   logic        busy;
   logic        slot_ok;
   logic        hold_idle;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         req_q     <= 1'b0;
         addr_q    <= '0;
         inst_q    <= '0;
         ipc_q     <= '0;
         valid_q   <= 1'b0;
         drop_q    <= 1'b0;
         skid_q    <= '0;
         skid_pc_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         mis_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         inst_q    <= inst_d;
         ipc_q     <= ipc_d;
         valid_q   <= valid_d;
         drop_q    <= drop_d;
         skid_q    <= skid_d;
         skid_pc_q <= skid_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         mis_q     <= mis_d;
`endif
      end
   end

   // Next state: redirect first, then ack/consume/skid, then issue
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_d     = req_q;
      addr_d    = addr_q;
      inst_d    = inst_q;
      ipc_d     = ipc_q;
      valid_d   = valid_q;
      drop_d    = drop_q;
      skid_d    = skid_q;
      skid_pc_d = skid_pc_q;
      hold_idle = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d     = mis_q;
      hold_idle = mis_q;
`endif

      redirect = flush_i | branch_flag_i;
      tgt      = flush_i ? new_pc_i : branch_target_i;
      fire     = req_q & imem.imem_ack_i;
      busy     = req_q & ~imem.imem_ack_i;
      slot_ok  = ~valid_q | ~stall_i;

      if (fire) begin
         req_d = 1'b0;
      end

      if (redirect) begin
         // Any data returning this edge is stale; a still-open
         // request must be swallowed when it finally acks.
         valid_d = 1'b0;
         drop_d  = busy;
         slot_ok = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
         pc_d    = tgt;
         mis_d   = (|tgt[1:0]) | (mis_q & ~flush_i);
         state_d = mis_d ? IDLE : REQ;
`else
         pc_d    = tgt & ~32'h3;
         state_d = REQ;
`endif
      end else begin
         if (valid_q && !stall_i) begin
            valid_d = 1'b0;
         end
         if (fire) begin
            if (drop_q) begin
               drop_d = 1'b0;
            end else if (slot_ok) begin
               inst_d  = imem.imem_rdata_i;
               ipc_d   = addr_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'(PC_STEP);
            end else begin
               skid_d    = imem.imem_rdata_i;
               skid_pc_d = addr_q;
               pc_d      = pc_q + 32'(PC_STEP);
               state_d   = SKID;
            end
         end
         unique case (state_q)
            IDLE: begin
               if (!hold_idle) begin
                  state_d = REQ;
               end
            end
            SKID: begin
               if (!stall_i) begin
                  inst_d  = skid_q;
                  ipc_d   = skid_pc_q;
                  valid_d = 1'b1;
                  state_d = REQ;
               end
            end
            default: ;
         endcase
      end

      // Only one request in flight; hold off while decode is stalled
      if (state_d == REQ && !busy && slot_ok) begin
         req_d  = 1'b1;
         addr_d = pc_d;
      end
   end

   assign imem.imem_req_o  = req_q;
   assign imem.imem_addr_o = addr_q;
   assign inst_o           = inst_q;
   assign inst_pc_o        = ipc_q;
   assign inst_valid_o     = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign misalign_o       = mis_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus
// hand sequences for mid-transaction reset and PC wrap.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic [31:0] tgt = '0;
   logic        fl = 1'b0;
   logic [31:0] npc = '0;
   logic [31:0] inst;
   logic [31:0] ipc;
   logic        valid;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        mis;
`endif

   fetch_ctrl_if bus ();

   fetch_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall),
      .branch_flag_i   (br),
      .branch_target_i (tgt),
      .flush_i         (fl),
      .new_pc_i        (npc),
      .imem            (bus),
      .inst_o          (inst),
      .inst_pc_o       (ipc),
      .inst_valid_o    (valid)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .misalign_o      (mis)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        fl;
      logic [31:0] npc;
      logic        ack;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_ipc;
      logic        e_mis;
   } vec_t;

   vec_t tbl[$];
   int   n_run  = 0;
   int   n_fail = 0;

   function automatic logic [31:0] dw(input logic [31:0] a);
      return 32'hD000_0000 | a;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic add(
      input logic s, input logic b, input logic [31:0] t,
      input logic f, input logic [31:0] n,
      input logic a, input logic [31:0] r,
      input logic er, input logic [31:0] ea,
      input logic ev, input logic [31:0] ei,
      input logic [31:0] ep, input logic em);
      vec_t v;
      v.stall = s;  v.br = b;  v.tgt = t;  v.fl = f;  v.npc = n;
      v.ack = a;    v.rd = r;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev;
      v.e_inst = ei; v.e_ipc = ep; v.e_mis = em;
      tbl.push_back(v);
   endtask

   initial begin
      bus.imem_ack_i   = 1'b0;
      bus.imem_rdata_i = '0;

      //  st br tgt        fl npc        ack rd
      //  req addr         vld inst         ipc    mis
      add(0,0,0,         0,0,         0,0,
          0,0,           0,0,             0,     0); // c0 idle
      add(0,0,0,         0,0,         1,dw(0),
          1,0,           0,0,             0,     0); // c1
      add(0,0,0,         0,0,         1,dw(4),
          1,4,           1,dw(0),         0,     0); // c2
      add(0,0,0,         0,0,         0,0,
          1,8,           1,dw(4),         4,     0); // c3 slow ack
      add(0,0,0,         0,0,         0,0,
          1,8,           0,0,             0,     0); // c4
      add(0,0,0,         0,0,         0,0,
          1,8,           0,0,             0,     0); // c5
      add(0,0,0,         0,0,         1,dw(8),
          1,8,           0,0,             0,     0); // c6
      add(1,0,0,         0,0,         1,dw(32'hC),
          1,32'hC,       1,dw(8),         8,     0); // c7 to skid
      add(1,0,0,         0,0,         0,0,
          0,0,           1,dw(8),         8,     0); // c8 held
      add(0,0,0,         0,0,         0,0,
          0,0,           1,dw(8),         8,     0); // c9 release
      add(0,0,0,         0,0,         1,dw(32'h10),
          1,32'h10,      1,dw(32'hC),     32'hC, 0); // c10 skid out
      add(0,0,0,         0,0,         0,0,
          1,32'h14,      1,dw(32'h10),    32'h10,0); // c11
      add(0,1,32'h100,   0,0,         0,0,
          1,32'h14,      0,0,             0,     0); // c12 branch
      add(0,0,0,         0,0,         1,dw(32'h14),
          1,32'h14,      0,0,             0,     0); // c13 dropped
      add(0,0,0,         0,0,         1,dw(32'h100),
          1,32'h100,     0,0,             0,     0); // c14
      add(0,1,32'h200,   1,32'h380,   1,dw(32'h104),
          1,32'h104,     1,dw(32'h100),   32'h100,0); // c15 flush wins
      add(0,0,0,         0,0,         1,dw(32'h380),
          1,32'h380,     0,0,             0,     0); // c16
      add(0,1,32'h102,   0,0,         0,0,
          1,32'h384,     1,dw(32'h380),   32'h380,0); // c17 odd tgt
`ifdef FETCH_MISALIGN_CHECK_EN
      add(0,0,0,         0,0,         1,dw(32'h384),
          1,32'h384,     0,0,             0,     1); // c18 dropped
      add(0,0,0,         1,32'h380,   0,0,
          0,0,           0,0,             0,     1); // c19 no req
      add(0,0,0,         0,0,         0,0,
          1,32'h380,     0,0,             0,     0); // c20 resumed
`else
      add(0,0,0,         0,0,         1,dw(32'h384),
          1,32'h384,     0,0,             0,     0); // c18 dropped
      add(0,0,0,         0,0,         1,dw(32'h100),
          1,32'h100,     0,0,             0,     0); // c19 masked
      add(0,0,0,         0,0,         0,0,
          1,32'h104,     1,dw(32'h100),   32'h100,0); // c20
`endif

      // Reset state
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst req",   32'(bus.imem_req_o), 32'd0);
      chk("rst addr",  bus.imem_addr_o, 32'd0);
      chk("rst valid", 32'(valid), 32'd0);
      chk("rst inst",  inst, 32'd0);
      chk("rst ipc",   ipc, 32'd0);

      rst = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         if (i != 0) @(negedge clk);
         stall            = tbl[i].stall;
         br               = tbl[i].br;
         tgt              = tbl[i].tgt;
         fl               = tbl[i].fl;
         npc              = tbl[i].npc;
         bus.imem_ack_i   = tbl[i].ack;
         bus.imem_rdata_i = tbl[i].rd;
         #1;
         chk($sformatf("c%0d req", i), 32'(bus.imem_req_o),
             32'(tbl[i].e_req));
         if (tbl[i].e_req)
            chk($sformatf("c%0d addr", i), bus.imem_addr_o,
                tbl[i].e_addr);
         chk($sformatf("c%0d valid", i), 32'(valid),
             32'(tbl[i].e_valid));
         if (tbl[i].e_valid) begin
            chk($sformatf("c%0d inst", i), inst, tbl[i].e_inst);
            chk($sformatf("c%0d ipc", i), ipc, tbl[i].e_ipc);
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         chk($sformatf("c%0d mis", i), 32'(mis), 32'(tbl[i].e_mis));
`endif
      end

      // Reset while a request is still open
      @(negedge clk);
      rst = 1'b1;
      stall = 1'b0; br = 1'b0; fl = 1'b0;
      bus.imem_ack_i = 1'b0;
      @(negedge clk);
      chk("mrst req",   32'(bus.imem_req_o), 32'd0);
      chk("mrst addr",  bus.imem_addr_o, 32'd0);
      chk("mrst valid", 32'(valid), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mrst mis",   32'(mis), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("mrst first req",  32'(bus.imem_req_o), 32'd1);
      chk("mrst first addr", bus.imem_addr_o, 32'd0);

      // Branch to the top word, then check PC wraps to zero
      br  = 1'b1;
      tgt = 32'hFFFF_FFFC;
      @(negedge clk);
      br = 1'b0;
      bus.imem_ack_i   = 1'b1;
      bus.imem_rdata_i = 32'hDEAD_0000;
      @(negedge clk);
      chk("wrap valid0", 32'(valid), 32'd0);
      chk("wrap addr",   bus.imem_addr_o, 32'hFFFF_FFFC);
      bus.imem_rdata_i = 32'h1234_5678;
      @(negedge clk);
      bus.imem_ack_i = 1'b0;
      chk("wrap next",  bus.imem_addr_o, 32'h0000_0000);
      chk("wrap inst",  inst, 32'h1234_5678);
      chk("wrap ipc",   ipc, 32'hFFFF_FFFC);
      chk("wrap valid", 32'(valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
